// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch_ctrl shared types and default address constants
package fetch_pkg;

  typedef enum logic [1:0] {
    REFILL = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_LIMIT   = 32'h0000_4ffc;
  localparam logic [31:0] NOP            = 32'h0000_0000;

endpackage

// File: rtl/fetch_addr_check.sv
// rtl/fetch_addr_check.sv - combinational AdEL check of a fetch address
module fetch_addr_check #(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_4ffc
) (
  input  logic [31:0] addr,
  output logic        adel
);

  assign adel = (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch sequencer; FETCH_ADEL_EN enables AdEL range/alignment checking
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] IM_BASE    = DEF_IM_BASE,
  parameter logic [31:0] IM_LIMIT   = DEF_IM_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [11:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  fetch_state_e state, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  cur_instr;
  logic         rsp_adel;
  logic         advance;

`ifdef FETCH_ADEL_EN
  logic        rsp_adel_q, rsp_adel_d;
  logic        issue_adel;
  logic [31:0] im_off;

  fetch_addr_check #(
    .IM_BASE  (IM_BASE),
    .IM_LIMIT (IM_LIMIT)
  ) u_addr_check (
    .addr (pc_q),
    .adel (issue_adel)
  );

  assign im_off   = pc_q - IM_BASE;
  assign im_addr  = im_off[13:2];
  assign rsp_adel = rsp_adel_q;
`else
  assign im_addr  = pc_q[13:2];
  assign rsp_adel = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    hold_d    = hold_q;
    advance   = 1'b0;
`ifdef FETCH_ADEL_EN
    rsp_adel_d = rsp_adel_q;
`endif

    // STALL replays the captured word; RUN shows the memory response directly
    cur_instr = (state == STALL) ? hold_q : (rsp_adel ? NOP : im_rdata);
    if_valid  = (state != REFILL) && !exc_req && !eret_req;
    if_pc     = rsp_pc_q;
    if_instr  = if_valid ? cur_instr : NOP;
    if_adel   = if_valid && rsp_adel;

    if (exc_req) begin
      pc_d    = HANDLER_PC;
      state_d = REFILL;
    end else if (eret_req) begin
      pc_d    = epc;
      state_d = REFILL;
    end else if (br_valid && !stall) begin
      pc_d    = br_target;
      state_d = REFILL;
    end else if (stall && state != REFILL) begin
      if (state == RUN) hold_d = cur_instr;
      state_d = STALL;
    end else begin
      advance = 1'b1;
    end

    // pc_q stays put across a stall, so memory already holds its data on release
    if (advance) begin
      rsp_pc_d = pc_q;
      pc_d     = pc_q + 32'd4;
      state_d  = RUN;
`ifdef FETCH_ADEL_EN
      rsp_adel_d = issue_adel;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= REFILL;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      hold_q   <= NOP;
`ifdef FETCH_ADEL_EN
      rsp_adel_q <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      hold_q   <= hold_d;
`ifdef FETCH_ADEL_EN
      rsp_adel_q <= rsp_adel_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a PC-sequence model
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] HND_PC  = 32'h0000_4180;
  localparam logic [31:0] BASE    = 32'h0000_3000;
  localparam logic [31:0] LIMIT   = 32'h0000_4ffc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [11:0] im_addr;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;

  logic [31:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  // model: what is presented, and the next sequential fetch address
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;

  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .im_addr   (im_addr),
    .im_rdata  (im_rdata),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_adel   (if_adel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_rdata <= mem[im_addr];

  function automatic logic [11:0] word_idx(input logic [31:0] a);
    logic [31:0] o;
`ifdef FETCH_ADEL_EN
    o = a - BASE;
`else
    o = a;
`endif
    return o[13:2];
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
    return (a % 4 != 0) || (a < BASE) || (a > LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return BASE + 4 * $urandom_range(0, 2047);
    else if (r == 7) return BASE + $urandom_range(0, 8191);
    else if (r == 8) return $urandom;
    else             return 32'hffff_fff8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                      input logic ex, input logic er, input logic [31:0] ep);
    logic        ev, ea;
    logic [31:0] ei;
    @(negedge clk);
    reset = rst; stall = st; br_valid = br; br_target = bt;
    exc_req = ex; eret_req = er; epc = ep;
    #1;
    ev = m_valid && !ex && !er;
    ea = ev && is_bad(m_pc);
    ei = (ev && !ea) ? mem[word_idx(m_pc)] : 32'h0;
    check("if_valid", {31'b0, if_valid}, {31'b0, ev});
    check("if_pc", if_pc, m_pc);
    check("if_instr", if_instr, ei);
    check("if_adel", {31'b0, if_adel}, {31'b0, ea});
    check("im_addr", {20'b0, im_addr}, {20'b0, word_idx(m_next)});
    o_valid = if_valid; o_pc = if_pc; o_instr = if_instr;
    if (!rst) begin
      m_valid = 1'b0; m_pc = RST_PC; m_next = RST_PC;
    end else if (ex) begin
      m_valid = 1'b0; m_next = HND_PC;
    end else if (er) begin
      m_valid = 1'b0; m_next = ep;
    end else if (br && !st) begin
      m_valid = 1'b0; m_next = bt;
    end else if (!(st && m_valid)) begin
      m_valid = 1'b1; m_pc = m_next; m_next = m_next + 32'd4;
    end
  endtask

  task automatic idle(input logic st);
    step(1'b1, st, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_eret(input logic [31:0] ep);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ep);
    idle(1'b0);
    idle(1'b0);
    check("eret_pc", o_pc, ep);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[word_idx(RST_PC)] = 32'h3c01_0001;
    m_valid = 1'b0; m_pc = RST_PC; m_next = RST_PC;
    @(posedge clk);
    @(posedge clk);

    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'h0);
    check("rst_pc", o_pc, RST_PC);

    idle(1'b0);
    check("c1_valid", {31'b0, o_valid}, 32'h0);
    idle(1'b0);
    check("c2_pc", o_pc, 32'h3000);
    check("c2_instr", o_instr, 32'h3c01_0001);
    idle(1'b0);
    check("c3_pc", o_pc, 32'h3004);

    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("stall_pc", o_pc, 32'h3008);
    end
    idle(1'b0);
    check("stall_rel_pc", o_pc, 32'h3008);
    idle(1'b0);
    check("after_stall_pc", o_pc, 32'h300c);

    step(1'b1, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
    check("slot_pc", o_pc, 32'h3010);
    check("slot_valid", {31'b0, o_valid}, 32'h1);
    idle(1'b0);
    check("br_bubble", {31'b0, o_valid}, 32'h0);
    idle(1'b0);
    check("br_target_pc", o_pc, 32'h3100);

    step(1'b1, 1'b0, 1'b1, 32'h3200, 1'b1, 1'b0, 32'h0);
    check("exc_flush", {31'b0, o_valid}, 32'h0);
    idle(1'b0);
    idle(1'b0);
    check("handler_pc", o_pc, 32'h4180);

    do_eret(32'h0000_3002);
    do_eret(32'h0000_5000);
    do_eret(32'hffff_fffc);
    idle(1'b0);
    check("wrap_pc", o_pc, 32'h0);

    idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle(1'b0);
    check("rst_exc_valid", {31'b0, o_valid}, 32'h0);
    check("rst_exc_pc", o_pc, RST_PC);
    idle(1'b0);
    check("rst_exc_first", o_pc, RST_PC);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 10, rand_addr(),
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 3, rand_addr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
